uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Shares one UART transmit line among `NUM_REQ` byte-stream requesters (debug monitor, status reporter, and others) using round-robin arbitration with per-message locking. A requester keeps the line until it sends a byte marked `req_last`, so multi-byte messages are never interleaved. The block contains its own bit-period timing, derived from the 50 MHz system clock, and serialises 8N1 frames onto `tx`. It sits between the monitor's message sources and the board UART pin.

## Interface
- `CLK_FRQ`, 50_000_000, system clock frequency in Hz.
- `BAUD_RATE`, 115200, line rate. `BIT_TICKS = CLK_FRQ / BAUD_RATE` (integer division), which is 434 at the defaults.
- `NUM_REQ`, 4, number of requesters. Valid range is 2–8.
- `HOLD_TIMEOUT`, 16, number of bit periods a locked, idle requester may stall before its lock is revoked.

Ports:
- `clk` — input, 1 bit, system clock.
- `reset` — input, 1 bit. Synchronous, active-high.
- `req_valid` — input, `NUM_REQ` bits. Requester i has a byte pending.
- `req_data` — input, `NUM_REQ`×8 bits. Byte for requester i.
- `req_last` — input, `NUM_REQ` bits. This byte ends requester i's message.
- `req_ready` — output, `NUM_REQ` bits, one-hot or zero. Byte is accepted when `req_valid[i] & req_ready[i]`.
- `tx` — output, 1 bit. Serial line, idles high.
- `busy` — output, 1 bit. High in START, DATA, STOP and HOLD.
- `grant_id` — output, `$clog2(NUM_REQ)` bits. Current or last granted requester.

## Operation
States: IDLE, START, DATA, STOP, HOLD.

- **IDLE**
  - Selects the first i with `req_valid[i]=1`, scanning from `rr_ptr` upward and wrapping.
  - `req_ready[i]` is driven combinationally for that i only.
  - On acceptance: latch the byte and `req_last[i]`, set `grant_id=i`, go to START.
- **START**
  - `tx=0` for one bit period, then go to DATA with bit index 0.
- **DATA**
  - `tx` = latched byte bit `idx`, LSB first, for one bit period each.
  - After `idx=7`, go to STOP.
- **STOP**
  - `tx=1` for one bit period.
  - At the end of the period:
    - If the latched `last=1`: `rr_ptr <= (grant_id+1) mod NUM_REQ`, go to IDLE.
    - Otherwise go to HOLD.
- **HOLD**
  - `tx=1`. `req_ready[grant_id]` is driven combinationally; no other requester may be granted.
  - On acceptance, go to START.
  - After `HOLD_TIMEOUT` full bit periods with no acceptance: release the lock (advance `rr_ptr` as above) and go to IDLE.
- Bit timer: a counter from 0 to `BIT_TICKS-1`.
  - Cleared on every acceptance and every state entry.
  - `bit_done` asserts in the cycle the count equals `BIT_TICKS-1`.
- `req_ready` is all-zero in START, DATA and STOP, and during reset.
- A change in `req_valid` or `req_data` while not ready has no effect. Input bytes are sampled only on acceptance.

## Timing
- Reset values: `tx=1`, `busy=0`, `req_ready=0`, `grant_id=0`, `rr_ptr=0`, state IDLE, timers 0.
- Acceptance in cycle t: `tx` falls at t+1.
- Each bit lasts exactly `BIT_TICKS` cycles. The frame occupies t+1 … t+10·`BIT_TICKS`.
- The next acceptance is possible in cycle t+10·`BIT_TICKS`+1 (the IDLE or HOLD cycle), so back-to-back frames have zero idle bits.
- Simultaneous requests: only the round-robin winner is readied. Others wait with no loss.
- `req_valid` from the locked requester arriving in the same cycle as the timeout expiry is accepted. Acceptance takes priority over the timeout.
- Reset mid-frame: the frame is truncated, `tx=1` from the next cycle, the lock is released and the byte is discarded.
- `grant_id` changes only on acceptance.

## Structure
- Shared package `uart_pkg`:
  - state enum `tx_state_t`;
  - function `bit_ticks(clk_frq, baud)`;
  - constants `UART_DATA_BITS=8` and `UART_STOP_BITS=1`.
- Sub-module `uart_bit_timer`:
  - parameter `BIT_TICKS`;
  - inputs `clk`, `reset`, `restart`;
  - output `bit_done` (1-cycle strobe).
- The arbiter, FSM and shift register live in `uart_tx_scheduler`.

## Test plan
Bench parameters: `CLK_FRQ=1_000_000`, `BAUD_RATE=100_000`, giving `BIT_TICKS=10`.

1. Single byte: requester 0 sends 0xA5 with last=1.
   - `tx` low for 10 cycles, then 1,0,1,0,0,1,0,1 for 10 cycles each, then high.
   - `busy` drops at cycle 101 after acceptance.
2. Contention: all four request at once with last=1.
   - Grant order is 0,1,2,3.
   - Repeating from `rr_ptr=0` with requesters 1 and 3 active gives order 1,3.
3. Locked message: requester 2 sends 0x11, 0x22, 0x33 with last on 0x33, while requester 0 is continuously valid.
   - The three frames go out back-to-back.
   - Requester 0 is granted only after 0x33's stop bit.
4. Hold timeout: requester 1 sends a byte with last=0, then goes silent, while requester 3 is valid.
   - HOLD lasts 160 cycles.
   - Requester 3 is accepted on the next IDLE cycle.
5. Reset in the middle of DATA bit 4:
   - `tx=1` and `req_ready=0` on the next cycle.
   - A new request after reset produces a clean full frame.
6. Handshake rule: `req_valid` toggles during a frame.
   - No acceptance occurs, and `req_ready` stays 0 throughout START, DATA and STOP.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Frame state, bit-period helper and 8N1 framing constants.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_HOLD
  } tx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;

  function automatic int bit_ticks(
    input int clk_frq,
    input int baud
  );
    return clk_frq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-side byte stream bundle for the UART scheduler.
// One valid/ready/last lane and one byte lane per requester.
interface uart_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ*UART_DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]                req_last;
  logic [NUM_REQ-1:0]                req_ready;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    output req_ready
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..BIT_TICKS-1 and strobes bit_done
// on the last count; restart forces the count back to zero.
module uart_bit_timer #(
  parameter int BIT_TICKS = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic bit_done
);

  localparam int CW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;

  logic [CW-1:0] r_cnt;

  assign bit_done = (r_cnt == CW'(BIT_TICKS - 1));

  always_ff @(posedge clk) begin
    if (reset || restart || bit_done) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin, message-locked sharing of one 8N1 UART TX line
// among NUM_REQ byte-stream requesters.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int CLK_FRQ      = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  uart_tx_scheduler_if.slave         bus,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int BIT_TICKS = bit_ticks(CLK_FRQ, BAUD_RATE);
  localparam int IDW       = $clog2(NUM_REQ);
  localparam int HW        = $clog2(HOLD_TIMEOUT + 1);

  tx_state_t          r_state;
  logic [IDW-1:0]     r_grant;
  logic [IDW-1:0]     r_rr;
  logic [7:0]         r_shift;
  logic               r_last;
  logic [2:0]         r_idx;
  logic [HW-1:0]      r_hold;

  logic [IDW-1:0]     w_j;
  logic [IDW-1:0]     w_sel;
  logic               w_found;
  logic [IDW-1:0]     w_ridx;
  logic               w_ren;
  logic               w_acc;
  logic               w_done;
  logic [7:0]         w_byte;
  logic [IDW-1:0]     w_nxt;
  logic [NUM_REQ-1:0] w_ready;

  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_j = (int'(r_rr) + k >= NUM_REQ)
          ? IDW'(int'(r_rr) + k - NUM_REQ)
          : IDW'(int'(r_rr) + k);
      if (!w_found && bus.req_valid[w_j]) begin
        w_found = 1'b1;
        w_sel   = w_j;
      end
    end
  end

  // Only IDLE arbitrates; HOLD offers the line to the lock owner alone.
  always_comb begin
    w_ridx = r_grant;
    w_ren  = 1'b0;
    if (r_state == S_IDLE) begin
      w_ridx = w_sel;
      w_ren  = w_found;
    end else if (r_state == S_HOLD) begin
      w_ridx = r_grant;
      w_ren  = 1'b1;
    end
    if (reset) begin
      w_ren = 1'b0;
    end
    w_ready = w_ren ? (NUM_REQ'(1) << w_ridx) : '0;
  end

  assign bus.req_ready = w_ready;
  assign w_acc    = w_ren & bus.req_valid[w_ridx];
  assign w_byte   = bus.req_data[{w_ridx, 3'b000} +: 8];
  assign w_nxt    = (r_grant == IDW'(NUM_REQ - 1))
                  ? '0 : r_grant + 1'b1;
  assign grant_id = r_grant;

  uart_bit_timer #(
    .BIT_TICKS(BIT_TICKS)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .restart (w_acc),
    .bit_done(w_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_rr    <= '0;
      r_shift <= '0;
      r_last  <= 1'b0;
      r_idx   <= '0;
      r_hold  <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_acc) begin
            r_shift <= w_byte;
            r_last  <= bus.req_last[w_ridx];
            r_grant <= w_ridx;
            r_hold  <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_START;
          end else if (r_state == S_HOLD && w_done) begin
            if (r_hold == HW'(HOLD_TIMEOUT - 1)) begin
              r_rr    <= w_nxt;
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
        end
        S_START: begin
          if (w_done) begin
            tx      <= r_shift[0];
            r_idx   <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_done) begin
            if (r_idx == 3'(UART_DATA_BITS - 1)) begin
              tx      <= 1'b1;
              r_state <= S_STOP;
            end else begin
              tx      <= r_shift[1];
              r_shift <= {1'b0, r_shift[7:1]};
              r_idx   <= r_idx + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (w_done) begin
            if (r_last) begin
              r_rr    <= w_nxt;
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_hold  <= '0;
              r_state <= S_HOLD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: queued requesters, an ordering model
// and cycle-exact 8N1 frame checks at BIT_TICKS=10.
module tb_uart_tx_scheduler;

  typedef struct {
    int         r;
    logic [7:0] d;
    bit         l;
    int         at;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx;
  logic       busy;
  logic [1:0] gid;

  uart_tx_scheduler_if #(.NUM_REQ(4)) bus ();

  uart_tx_scheduler #(
    .CLK_FRQ     (1_000_000),
    .BAUD_RATE   (100_000),
    .NUM_REQ     (4),
    .HOLD_TIMEOUT(16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .tx      (tx),
    .busy    (busy),
    .grant_id(gid)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc = 0;
  int bad_rdy = 0;
  int last_acc = -10;
  int noise_lo = 1;
  int noise_hi = 0;
  bit noise_arm = 1'b0;
  int head [4];
  int mptr;

  ent_t       src [$];
  int         acc_r [$];
  int         acc_c [$];
  logic [7:0] acc_d [$];
  int         exp_r [$];
  logic [7:0] exp_d [$];

  logic       tx_log   [16384];
  logic       busy_log [16384];
  logic [3:0] rdy_log  [16384];
  logic [1:0] gid_log  [16384];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    n_tot++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic bit in_noise();
    return (cyc >= noise_lo) && (cyc <= noise_hi);
  endfunction

  task automatic load(input int r, input logic [7:0] d,
                      input bit l, input int at);
    ent_t e;
    e.r = r; e.d = d; e.l = l; e.at = at;
    src.push_back(e);
  endtask

  task automatic drive();
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    v = '0; d = '0; l = '0;
    for (int r = 0; r < 4; r++) begin
      head[r] = -1;
      for (int k = 0; k < src.size(); k++) begin
        if (head[r] < 0 && src[k].r == r) head[r] = k;
      end
      if (head[r] >= 0 && src[head[r]].at <= cyc) begin
        v[r]        = 1'b1;
        d[r*8 +: 8] = src[head[r]].d;
        l[r]        = src[head[r]].l;
      end
    end
    if (in_noise()) begin
      v = 4'($urandom);
      d = $urandom;
      l = 4'($urandom);
    end
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_last  = l;
  endtask

  task automatic step();
    logic [3:0] hit;
    int r;
    @(negedge clk);
    tx_log[cyc]   = tx;
    busy_log[cyc] = busy;
    rdy_log[cyc]  = bus.req_ready;
    gid_log[cyc]  = gid;
    if (!$onehot0(bus.req_ready) || (reset && bus.req_ready != 0))
      bad_rdy++;
    hit = bus.req_valid & bus.req_ready;
    if (!reset && hit != 0) begin
      r = 0;
      for (int i = 3; i >= 0; i--) if (hit[i]) r = i;
      acc_r.push_back(r);
      acc_d.push_back(bus.req_data[r*8 +: 8]);
      acc_c.push_back(cyc);
      last_acc = cyc;
      if (!in_noise() && head[r] >= 0) src.delete(head[r]);
      if (noise_arm) begin
        noise_lo  = cyc + 1;
        noise_hi  = cyc + 100;
        noise_arm = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic clr();
    acc_r.delete(); acc_d.delete(); acc_c.delete();
    exp_r.delete(); exp_d.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src.delete();
    clr();
    noise_lo = 1; noise_hi = 0; noise_arm = 1'b0;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    last_acc = -10;
    drive();
  endtask

  task automatic run_quiet(input string tag, input int budget);
    int n;
    bit q;
    n = 0;
    q = 1'b0;
    while (!q && n < budget) begin
      step();
      n++;
      q = (src.size() == 0) && (busy_log[cyc-1] == 1'b0)
        && (last_acc != cyc - 1) && !in_noise();
    end
    chk({tag, "_settled"}, 32'(q), 32'd1);
  endtask

  // Reference ordering: round-robin over whole messages.
  task automatic model(inout int ptr);
    bit used [$];
    int left, found, j;
    bit done;
    used.delete();
    for (int k = 0; k < src.size(); k++) used.push_back(1'b0);
    left = src.size();
    while (left > 0) begin
      found = -1;
      for (int k = 0; k < 4; k++) begin
        for (int e = 0; e < src.size(); e++)
          if (found < 0 && !used[e] && src[e].r == (ptr + k) % 4)
            found = (ptr + k) % 4;
      end
      done = 1'b0;
      while (!done) begin
        j = -1;
        for (int e = 0; e < src.size(); e++)
          if (j < 0 && !used[e] && src[e].r == found) j = e;
        if (j < 0) begin
          done = 1'b1;
        end else begin
          used[j] = 1'b1;
          left--;
          exp_r.push_back(found);
          exp_d.push_back(src[j].d);
          done = src[j].l;
        end
      end
      ptr = (found + 1) % 4;
    end
  endtask

  task automatic frame(input string tag, input int t,
                       input logic [7:0] b);
    int errs, bi;
    logic e;
    errs = 0;
    for (int c = 1; c <= 100; c++) begin
      bi = (c - 1) / 10;
      e = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
      if (tx_log[t+c] !== e) errs++;
    end
    chk({tag, "_frame"}, 32'(errs), 32'd0);
  endtask

  task automatic verify(input string tag, input bit b2b);
    int n;
    chk({tag, "_count"}, 32'(acc_r.size()), 32'(exp_r.size()));
    n = (acc_r.size() < exp_r.size()) ? acc_r.size() : exp_r.size();
    for (int k = 0; k < n; k++) begin
      chk({tag, "_order"}, 32'(acc_r[k] * 256 + acc_d[k]),
          32'(exp_r[k] * 256 + exp_d[k]));
      frame(tag, acc_c[k], exp_d[k]);
      chk({tag, "_grant"}, 32'(gid_log[acc_c[k]+1]), 32'(exp_r[k]));
      if (b2b && k > 0)
        chk({tag, "_gap"}, 32'(acc_c[k] - acc_c[k-1]), 32'd101);
    end
  endtask

  initial begin
    int t, errs, errs2;
    logic [7:0] b;
    bus.req_valid = '0; bus.req_data = '0; bus.req_last = '0;

    do_reset();
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_grant", 32'(gid), 32'd0);

    do_reset();
    load(0, 8'hA5, 1'b1, 0);
    exp_r.push_back(0); exp_d.push_back(8'hA5);
    drive();
    run_quiet("single", 400);
    verify("single", 1'b0);
    if (acc_c.size() > 0) begin
      t = acc_c[0];
      chk("single_busy100", 32'(busy_log[t+100]), 32'd1);
      chk("single_busy101", 32'(busy_log[t+101]), 32'd0);
      chk("single_idle_tx", 32'(tx_log[t+101]), 32'd1);
    end

    do_reset();
    mptr = 0;
    for (int r = 0; r < 4; r++) load(r, 8'($urandom), 1'b1, 0);
    model(mptr);
    drive();
    run_quiet("contend", 1000);
    verify("contend", 1'b1);
    clr();
    load(1, 8'($urandom), 1'b1, 0);
    load(3, 8'($urandom), 1'b1, 0);
    model(mptr);
    drive();
    run_quiet("contend13", 600);
    verify("contend13", 1'b1);

    do_reset();
    b = 8'($urandom);
    load(2, 8'h11, 1'b0, 0);
    load(2, 8'h22, 1'b0, 0);
    load(2, 8'h33, 1'b1, 0);
    load(0, b, 1'b1, 1);
    exp_r = '{2, 2, 2, 0};
    exp_d = '{8'h11, 8'h22, 8'h33, b};
    drive();
    run_quiet("locked", 1000);
    verify("locked", 1'b1);

    do_reset();
    b = 8'($urandom);
    load(1, 8'h5C, 1'b0, 0);
    load(3, b, 1'b1, 0);
    exp_r = '{1, 3};
    exp_d = '{8'h5C, b};
    drive();
    run_quiet("hold", 1000);
    verify("hold", 1'b0);
    if (acc_c.size() >= 2) begin
      t = acc_c[0];
      chk("hold_gap", 32'(acc_c[1] - t), 32'd261);
      errs = 0;
      for (int c = t + 101; c <= t + 260; c++)
        if (rdy_log[c] !== 4'b0010 || tx_log[c] !== 1'b1
            || busy_log[c] !== 1'b1) errs++;
      chk("hold_window", 32'(errs), 32'd0);
    end

    do_reset();
    load(1, 8'h3C, 1'b0, 0);
    load(1, 8'hC3, 1'b1, 260);
    load(3, 8'h7E, 1'b1, 0);
    exp_r = '{1, 1, 3};
    exp_d = '{8'h3C, 8'hC3, 8'h7E};
    drive();
    run_quiet("hold_edge", 1000);
    verify("hold_edge", 1'b0);
    if (acc_c.size() >= 3) begin
      chk("hold_edge_gap0", 32'(acc_c[1] - acc_c[0]), 32'd260);
      chk("hold_edge_gap1", 32'(acc_c[2] - acc_c[1]), 32'd101);
    end

    do_reset();
    b = 8'($urandom);
    load(0, 8'hF0, 1'b1, 0);
    load(3, b, 1'b1, 50);
    drive();
    errs = 0;
    while (acc_c.size() == 0 && errs < 20) begin
      step();
      errs++;
    end
    chk("mid_first_acc", 32'(acc_c.size()), 32'd1);
    t = (acc_c.size() > 0) ? acc_c[0] : 0;
    while (cyc < t + 55) step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    run_quiet("mid", 400);
    chk("mid_tx", 32'(tx_log[t+56]), 32'd1);
    chk("mid_ready", 32'({rdy_log[t+55], rdy_log[t+56]}), 32'd0);
    chk("mid_busy", 32'(busy_log[t+56]), 32'd0);
    chk("mid_grant", 32'(gid_log[t+56]), 32'd0);
    acc_r.delete(0); acc_d.delete(0); acc_c.delete(0);
    exp_r = '{3};
    exp_d = '{b};
    verify("mid_after", 1'b0);
    if (acc_c.size() > 0)
      chk("mid_after_cyc", 32'(acc_c[0]), 32'(t + 57));

    do_reset();
    noise_arm = 1'b1;
    b = 8'($urandom);
    load(0, b, 1'b1, 0);
    exp_r = '{0};
    exp_d = '{b};
    drive();
    run_quiet("noise", 400);
    verify("noise", 1'b0);
    if (acc_c.size() > 0) begin
      errs2 = 0;
      for (int c = acc_c[0] + 1; c <= acc_c[0] + 100; c++)
        if (rdy_log[c] !== 4'b0000) errs2++;
      chk("noise_ready", 32'(errs2), 32'd0);
    end

    do_reset();
    mptr = 0;
    for (int round = 0; round < 3; round++) begin
      int n;
      bit any;
      clr();
      any = 1'b0;
      for (int r = 0; r < 4; r++) begin
        if ($urandom_range(0, 1) == 1) begin
          any = 1'b1;
          n = $urandom_range(1, 3);
          for (int i = 0; i < n; i++)
            load(r, 8'($urandom), (i == n - 1), 0);
        end
      end
      if (!any) load($urandom_range(0, 3), 8'($urandom), 1'b1, 0);
      model(mptr);
      drive();
      run_quiet("random", 2000);
      verify("random", 1'b1);
    end

    chk("ready_onehot", 32'(bad_rdy), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
